// File: rtl/sram_port_arbiter_if.sv
// Bundle of the requester-side OBI-like handshake and the SRAM port signals.
// The arbiter takes the slave view; the masters/SRAM side takes the master view.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*BE_WIDTH-1:0]   be;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  // SRAM side
  logic                          ram_en;
  logic                          ram_we;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [BE_WIDTH-1:0]           ram_be;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic [DATA_WIDTH-1:0]         ram_rdata;

  modport slave (
    input  req, we, addr, be, wdata, ram_rdata,
    output gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_be, ram_wdata
  );

  modport master (
    output req, we, addr, be, wdata, ram_rdata,
    input  gnt, rvalid, rdata, ram_en, ram_we, ram_addr, ram_be, ram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one SRAM RW port between
// NUM_REQ masters. Grants are combinational from req in the same cycle; the
// response (rvalid, plus rdata for reads) follows exactly one cycle later.
module sram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  sram_port_arbiter_if.slave bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // one spare bit so the incremented count never wraps before the compare
  localparam int CNT_W    = $clog2(MAX_BURST + 1) + 1;

  logic                   ready_r;
  logic [PTR_W-1:0]       ptr_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [NUM_REQ-1:0]     resp_vec_r;
  logic                   resp_rd_r;

  logic                   found_s;
  logic [PTR_W-1:0]       win_s;
  int                     scan_idx_s;
  logic                   accept_s;
  logic [NUM_REQ-1:0]     gnt_s;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic [PTR_W-1:0]       ptr_next_s;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   ram_we_s;
  logic [ADDR_WIDTH-1:0]  ram_addr_s;
  logic [BE_WIDTH-1:0]    ram_be_s;
  logic [DATA_WIDTH-1:0]  ram_wdata_s;

  // Find the first requesting master scanning upward from the priority pointer.
  always_comb begin
    found_s    = 1'b0;
    win_s      = {PTR_W{1'b0}};
    scan_idx_s = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx_s = int'(ptr_r) + off;
      if (scan_idx_s >= NUM_REQ) begin
        scan_idx_s = scan_idx_s - NUM_REQ;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!found_s && bus.req[scan_idx_s]) begin
        found_s = 1'b1;
        win_s   = PTR_W'(scan_idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Nothing is granted until the first edge after reset release has set ready.
  assign accept_s = ready_r & found_s;

  // One-hot grant and the SRAM request mux driven from the accepted master.
  always_comb begin
    gnt_s       = {NUM_REQ{1'b0}};
    ram_we_s    = 1'b0;
    ram_addr_s  = {ADDR_WIDTH{1'b0}};
    ram_be_s    = {BE_WIDTH{1'b0}};
    ram_wdata_s = {DATA_WIDTH{1'b0}};
    if (accept_s) begin
      gnt_s[win_s] = 1'b1;
      ram_we_s     = bus.we[win_s];
      ram_addr_s   = bus.addr[int'(win_s)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_be_s     = bus.be[int'(win_s)*BE_WIDTH +: BE_WIDTH];
      ram_wdata_s  = bus.wdata[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      gnt_s = {NUM_REQ{1'b0}};
    end
  end

  // Burst accounting: stay on the winner until it has had MAX_BURST grants in a row.
  always_comb begin
    ptr_next_s = ptr_r;
    cnt_next_s = {CNT_W{1'b0}};
    cnt_inc_s  = (win_s == ptr_r) ? (cnt_r + CNT_W'(1)) : CNT_W'(1);
    if (accept_s) begin
      if (cnt_inc_s >= CNT_W'(MAX_BURST)) begin
        cnt_next_s = {CNT_W{1'b0}};
        if (win_s == PTR_W'(NUM_REQ - 1)) begin
          ptr_next_s = {PTR_W{1'b0}};
        end else begin
          ptr_next_s = win_s + PTR_W'(1);
        end
      end else begin
        ptr_next_s = win_s;
        cnt_next_s = cnt_inc_s;
      end
    end else begin
      // a burst ends as soon as nobody is accepted
      ptr_next_s = ptr_r;
      cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // Arbitration state and the one-deep response register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_r    <= 1'b0;
      ptr_r      <= {PTR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      resp_vec_r <= {NUM_REQ{1'b0}};
      resp_rd_r  <= 1'b0;
    end else begin
      ready_r    <= 1'b1;
      ptr_r      <= ptr_next_s;
      cnt_r      <= cnt_next_s;
      resp_vec_r <= gnt_s;
      resp_rd_r  <= accept_s & ~bus.we[win_s];
    end
  end

  assign bus.gnt       = gnt_s;
  assign bus.rvalid    = resp_vec_r;
  assign bus.rdata     = resp_rd_r ? bus.ram_rdata : {DATA_WIDTH{1'b0}};
  assign bus.ram_en    = accept_s;
  assign bus.ram_we    = ram_we_s;
  assign bus.ram_addr  = ram_addr_s;
  assign bus.ram_be    = ram_be_s;
  assign bus.ram_wdata = ram_wdata_s;

endmodule
